// File: rtl/elastic_fifo_break_dv.sv
// elastic_fifo_break_dv
//   Elastic FIFO that buffers the selector's result channel. Both handshake
//   outputs come from internal state only: ins_ready is derived from the
//   occupancy count and reset, and outs_valid from the occupancy count. This
//   cuts the combinational valid/ready paths through the selector's join and
//   antitoken logic. The FIFO is lossless and in-order, and it has no bypass.
//   A token therefore reaches the output one cycle after it is accepted at
//   the earliest.
//
// Parameters
//   DATA_TYPE  payload width in bits (>=1)
//   NUM_SLOTS  storage depth in entries (>=1; need not be a power of two)
//
// Ports
//   clk         in   clock; all state changes on the rising edge
//   reset       in   asynchronous, active-high reset
//   ins         in   input payload
//   ins_valid   in   input token valid
//   ins_ready   out  FIFO can accept a token this cycle
//   outs        out  head-of-queue payload (don't-care when outs_valid=0)
//   outs_valid  out  head entry present
//   outs_ready  in   consumer accepts the head entry this cycle

module elastic_fifo_break_dv #(
  parameter int DATA_TYPE = 32,
  parameter int NUM_SLOTS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  input  logic                 outs_ready
);

  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

  // Payload storage. It is not reset, because only the pointers and the
  // count decide which entries are live.
  logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Reset is folded into ins_ready so that no token is accepted while reset
  // is held. The count is already 0 during reset, so outs_valid is low then.
  assign ins_ready  = !full && !reset;
  assign outs_valid = !empty;

  assign push = ins_valid  && ins_ready;
  assign pop  = outs_valid && outs_ready;

  assign outs = mem_q[rd_ptr_q];

  // Next-state logic. The pointers wrap on an explicit compare with the last
  // slot index, because the depth need not be a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // A push can never land on the head slot while that slot is live. A push
  // needs !full, and when the FIFO is not full and not empty, wr_ptr differs
  // from rd_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ins;
    end
  end

endmodule
